// File: rtl/apb_mst_muxn.sv
// apb_mst_muxn: NUM-to-1 APB requester mux with registered round-robin arbitration and own SETUP/ACCESS phasing.
// Optional ACCESS watchdog enabled by defining APB_MUXN_TIMEOUT_EN.
module apb_mst_muxn #(
  parameter int NUM = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TO_CYCLES = 256,
  localparam int GW = (NUM > 1) ? $clog2(NUM) : 1,
  localparam int SW = DW / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM*AW-1:0] s_paddr,
  input  logic [NUM*DW-1:0] s_pwdata,
  input  logic [NUM-1:0]    s_psel,
  input  logic [NUM-1:0]    s_penable,
  input  logic [NUM-1:0]    s_pwrite,
  input  logic [NUM*SW-1:0] s_pstrb,
  output logic [NUM-1:0]    s_pready,
  output logic [NUM-1:0]    s_pslverr,
  output logic [NUM*DW-1:0] s_prdata,
  output logic [AW-1:0]     m_paddr,
  output logic [DW-1:0]     m_pwdata,
  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  output logic [SW-1:0]     m_pstrb,
  input  logic              m_pready,
  input  logic              m_pslverr,
  input  logic [DW-1:0]     m_prdata,
  output logic [GW-1:0]     gnt_id
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nx;
  logic [GW-1:0] ptr, gnt, pick, idx;
  logic active, held, done, abort, tmo, fin, unused;
  assign active = state != IDLE;
  assign held = s_psel[gnt];
  assign done = state == ACCESS && held && m_pready;
  // a granted requester dropping psel mid-transfer abandons it silently
  assign abort = active && !held;
  assign fin = done || abort || tmo;
  assign gnt_id = gnt;
`ifdef APB_MUXN_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] wd;
  assign tmo = state == ACCESS && held && !m_pready && wd == TW'(TO_CYCLES);
  assign unused = ^s_penable;
  always_ff @(posedge clk) begin
    if (rst || state_nx == SETUP) wd <= '0;
    else if (state == ACCESS) wd <= wd + 1'b1;
  end
`else
  assign tmo = 1'b0;
  assign unused = ^s_penable ^ (TO_CYCLES > 0);
`endif
  // highest offset first so the lowest offset from ptr wins
  always_comb begin
    pick = ptr;
    idx = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      idx = GW'((int'(ptr) + i) % NUM);
      if (s_psel[idx]) pick = idx;
    end
  end
  always_comb state_nx = state == IDLE ? (|s_psel ? SETUP : IDLE) : fin ? IDLE : ACCESS;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      gnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |s_psel) gnt <= pick;
      if (fin) ptr <= gnt == GW'(NUM - 1) ? '0 : gnt + 1'b1;
    end
  end
  assign m_psel = active;
  assign m_penable = state == ACCESS;
  assign m_paddr = active ? s_paddr[gnt*AW +: AW] : '0;
  assign m_pwdata = active ? s_pwdata[gnt*DW +: DW] : '0;
  assign m_pwrite = active && s_pwrite[gnt];
  assign m_pstrb = active ? s_pstrb[gnt*SW +: SW] : '0;
  always_comb begin
    s_pready = '0;
    s_pslverr = '0;
    s_prdata = '0;
    if (done || tmo) begin
      s_pready[gnt] = 1'b1;
      s_pslverr[gnt] = tmo || m_pslverr;
      s_prdata[gnt*DW +: DW] = tmo ? '0 : m_prdata;
    end
  end
endmodule

// File: tb/tb_apb_mst_muxn.sv
// tb_apb_mst_muxn: scoreboard bench for apb_mst_muxn; completions are matched against queued expectations.
module tb_apb_mst_muxn;
  localparam int NUM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = 2;
  typedef struct {
    logic [1:0] id;
    logic [31:0] addr, wdata, rdata;
    logic wr, err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [NUM*AW-1:0] s_paddr = '0;
  logic [NUM*DW-1:0] s_pwdata = '0;
  logic [NUM-1:0] s_psel = '0, s_penable = '0, s_pwrite = '0;
  logic [NUM*4-1:0] s_pstrb = '0;
  logic [NUM-1:0] s_pready, s_pslverr;
  logic [NUM*DW-1:0] s_prdata;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pwdata;
  logic m_psel, m_penable, m_pwrite;
  logic [3:0] m_pstrb;
  logic m_pready = 1'b0, m_pslverr = 1'b0;
  logic [DW-1:0] m_prdata = '0;
  logic [GW-1:0] gnt_id;
  int vecs = 0, errs = 0;
  exp_t q[$];
  exp_t e;
  logic [NUM-1:0] er, ee;
  logic [NUM*DW-1:0] ed;

  always #5 clk = ~clk;

  apb_mst_muxn #(.NUM(NUM), .AW(AW), .DW(DW), .TO_CYCLES(256)) dut (
    .clk(clk), .rst(rst), .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_psel(s_psel),
    .s_penable(s_penable), .s_pwrite(s_pwrite), .s_pstrb(s_pstrb), .s_pready(s_pready),
    .s_pslverr(s_pslverr), .s_prdata(s_prdata), .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata), .gnt_id(gnt_id)
  );

  // every completion must match the oldest queued expectation
  always @(negedge clk) begin
    if (s_pready != '0) begin
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_ready: s_pready=%b, required no completion", s_pready);
      end else begin
        e = q.pop_front();
        er = '0;
        er[e.id] = 1'b1;
        ee = '0;
        ee[e.id] = e.err;
        ed = '0;
        ed[e.id*DW +: DW] = e.rdata;
        if (s_pready !== er || gnt_id !== e.id || m_paddr !== e.addr || m_pwrite !== e.wr ||
            m_pwdata !== e.wdata || s_prdata !== ed || s_pslverr !== ee) begin
          errs++;
          $display("FAIL completion: got rdy=%b gnt=%0d addr=%h wr=%b wd=%h rd=%h err=%b, required rdy=%b gnt=%0d addr=%h wr=%b wd=%h rd=%h err=%b",
                   s_pready, gnt_id, m_paddr, m_pwrite, m_pwdata, s_prdata, s_pslverr,
                   er, e.id, e.addr, e.wr, e.wdata, ed, ee);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic sel, input logic wr, input logic [31:0] a, input logic [31:0] d);
    s_psel[i] = sel;
    s_penable[i] = sel;
    s_pwrite[i] = wr;
    s_paddr[i*AW +: AW] = a;
    s_pwdata[i*DW +: DW] = d;
    s_pstrb[i*4 +: 4] = wr ? 4'hf : 4'h0;
  endtask

  function automatic void push(input logic [1:0] id, input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] r, input logic err);
    exp_t x;
    x.id = id;
    x.wr = wr;
    x.addr = a;
    x.wdata = d;
    x.rdata = r;
    x.err = err;
    q.push_back(x);
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    s_psel = '1;
    repeat (3) tick;
    @(negedge clk);
    vecs++;
    if ({m_psel, m_penable, s_pready, s_pslverr} !== '0) begin
      errs++;
      $display("FAIL reset_ctrl: got psel=%b en=%b rdy=%b err=%b, required all 0", m_psel, m_penable, s_pready, s_pslverr);
    end
    vecs++;
    if (gnt_id !== 2'd0) begin
      errs++;
      $display("FAIL reset_gnt: got %0d, required 0", gnt_id);
    end
    vecs++;
    if (m_paddr !== '0 || m_pwdata !== '0 || s_prdata !== '0) begin
      errs++;
      $display("FAIL reset_data: got addr=%h wd=%h rd=%h, required 0", m_paddr, m_pwdata, s_prdata);
    end
    tick;
    s_psel = '0;
    s_penable = '0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    m_pready = 1'b1;
    m_prdata = '0;
    set_req(2, 1'b1, 1'b1, 32'h100, 32'hA5A5A5A5);
    push(2'd2, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b0);
    @(negedge clk);
    vecs++;
    if (m_psel !== 1'b0) begin
      errs++;
      $display("FAIL single_idle: got psel=%b, required 0", m_psel);
    end
    tick;
    @(negedge clk);
    vecs++;
    if ({m_psel, m_penable, m_pwrite} !== 3'b101 || gnt_id !== 2'd2 || m_paddr !== 32'h100 ||
        m_pwdata !== 32'hA5A5A5A5 || m_pstrb !== 4'hf || s_pready !== '0) begin
      errs++;
      $display("FAIL single_setup: got sel/en/wr=%b%b%b gnt=%0d addr=%h wd=%h strb=%h rdy=%b, required 101 2 100 a5a5a5a5 f 0000",
               m_psel, m_penable, m_pwrite, gnt_id, m_paddr, m_pwdata, m_pstrb, s_pready);
    end
    tick;
    @(negedge clk);
    vecs++;
    if ({m_psel, m_penable} !== 2'b11) begin
      errs++;
      $display("FAIL single_access: got sel/en=%b%b, required 11", m_psel, m_penable);
    end
    tick;
    set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_round_robin;
    int order[5];
    order = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    tick;
    rst = 1'b0;
    m_pready = 1'b1;
    m_prdata = 32'h1111_0000;
    m_pslverr = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 32'h200 + i * 4, 32'hC0DE_0000 + i);
    for (int k = 0; k < 5; k++)
      push(2'(order[k]), 1'b1, 32'h200 + order[k] * 4, 32'hC0DE_0000 + order[k], 32'h1111_0000, 1'b0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      vecs++;
      if (m_psel !== (k % 3 != 0) || m_penable !== (k % 3 == 2)) begin
        errs++;
        $display("FAIL rr_phase: cycle %0d got sel/en=%b%b, required %b%b", k, m_psel, m_penable, k % 3 != 0, k % 3 == 2);
      end
      if (k % 3 != 0) begin
        vecs++;
        if (gnt_id !== 2'(order[k / 3])) begin
          errs++;
          $display("FAIL rr_grant: cycle %0d got %0d, required %0d", k, gnt_id, order[k / 3]);
        end
      end
      if (k % 3 != 2) begin
        vecs++;
        if (s_pready !== '0) begin
          errs++;
          $display("FAIL rr_ready_quiet: cycle %0d got %b, required 0000", k, s_pready);
        end
      end
      tick;
    end
    s_psel = '0;
    s_penable = '0;
  endtask

  task automatic test_wait_read;
    m_pready = 1'b0;
    m_prdata = 32'hDEADBEEF;
    m_pslverr = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h300, 32'h0);
    push(2'd1, 1'b0, 32'h300, 32'h0, 32'hDEADBEEF, 1'b1);
    tick;
    for (int w = 0; w < 5; w++) begin
      tick;
      @(negedge clk);
      vecs++;
      if (m_penable !== 1'b1 || s_pready !== '0 || s_prdata !== '0 || s_pslverr !== '0) begin
        errs++;
        $display("FAIL wait_hold: wait %0d got en=%b rdy=%b rd=%h err=%b, required 1 0000 0 0000", w, m_penable, s_pready, s_prdata, s_pslverr);
      end
    end
    tick;
    m_pready = 1'b1;
    @(negedge clk);
    vecs++;
    if (s_prdata[DW +: DW] !== 32'hDEADBEEF || s_pslverr[1] !== 1'b1) begin
      errs++;
      $display("FAIL wait_done: got rd=%h err=%b, required deadbeef 1", s_prdata[DW +: DW], s_pslverr[1]);
    end
    tick;
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    m_prdata = '0;
    m_pslverr = 1'b0;
    @(negedge clk);
    vecs++;
    if (m_psel !== 1'b0 || s_prdata !== '0 || s_pslverr !== '0) begin
      errs++;
      $display("FAIL wait_after: got sel=%b rd=%h err=%b, required 0 0 0", m_psel, s_prdata, s_pslverr);
    end
  endtask

  task automatic test_reset_mid;
    m_pready = 1'b0;
    set_req(3, 1'b1, 1'b1, 32'h400, 32'h33333333);
    tick;
    tick;
    @(negedge clk);
    vecs++;
    if ({m_psel, m_penable} !== 2'b11 || gnt_id !== 2'd3) begin
      errs++;
      $display("FAIL rmid_access: got sel/en=%b%b gnt=%0d, required 11 3", m_psel, m_penable, gnt_id);
    end
    rst = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h410, 32'h0);
    tick;
    rst = 1'b0;
    m_pready = 1'b1;
    m_prdata = 32'h0BAD_F00D;
    push(2'd1, 1'b0, 32'h410, 32'h0, 32'h0BAD_F00D, 1'b0);
    push(2'd3, 1'b1, 32'h400, 32'h33333333, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    vecs++;
    if (m_psel !== 1'b0 || s_pready !== '0 || gnt_id !== 2'd0) begin
      errs++;
      $display("FAIL rmid_abort: got sel=%b rdy=%b gnt=%0d, required 0 0000 0", m_psel, s_pready, gnt_id);
    end
    tick;
    @(negedge clk);
    vecs++;
    if ({m_psel, m_penable} !== 2'b10 || gnt_id !== 2'd1) begin
      errs++;
      $display("FAIL rmid_first: got sel/en=%b%b gnt=%0d, required 10 1", m_psel, m_penable, gnt_id);
    end
    repeat (3) tick;
    @(negedge clk);
    vecs++;
    if ({m_psel, m_penable} !== 2'b10 || gnt_id !== 2'd3) begin
      errs++;
      $display("FAIL rmid_second: got sel/en=%b%b gnt=%0d, required 10 3", m_psel, m_penable, gnt_id);
    end
    tick;
    tick;
    s_psel = '0;
    s_penable = '0;
    m_prdata = '0;
  endtask

  task automatic test_protocol;
    m_pready = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h500, 32'h55);
    set_req(1, 1'b1, 1'b1, 32'h510, 32'h66);
    push(2'd1, 1'b1, 32'h510, 32'h66, 32'h0, 1'b0);
    tick;
    s_psel[0] = 1'b0;
    @(negedge clk);
    vecs++;
    if ({m_psel, m_penable} !== 2'b10 || gnt_id !== 2'd0 || s_pready !== '0) begin
      errs++;
      $display("FAIL proto_setup: got sel/en=%b%b gnt=%0d rdy=%b, required 10 0 0000", m_psel, m_penable, gnt_id, s_pready);
    end
    tick;
    @(negedge clk);
    vecs++;
    if (m_psel !== 1'b0 || s_pready !== '0) begin
      errs++;
      $display("FAIL proto_drop: got sel=%b rdy=%b, required 0 0000", m_psel, s_pready);
    end
    tick;
    @(negedge clk);
    vecs++;
    if (m_psel !== 1'b1 || gnt_id !== 2'd1 || m_paddr !== 32'h510) begin
      errs++;
      $display("FAIL proto_next: got sel=%b gnt=%0d addr=%h, required 1 1 510", m_psel, gnt_id, m_paddr);
    end
    tick;
    tick;
    s_psel = '0;
    s_penable = '0;
  endtask

  task automatic test_random;
    int p, idx, cyc;
    logic [3:0] mask, m, pend, seen;
    logic [31:0] ra[4], wv[4];
    logic [31:0] rv;
    logic rw[4];
    rst = 1'b1;
    tick;
    rst = 1'b0;
    p = 0;
    for (int r = 0; r < 8; r++) begin
      mask = 4'($urandom_range(1, 15));
      rv = $urandom;
      m_prdata = rv;
      m_pslverr = 1'b0;
      for (int i = 0; i < 4; i++) begin
        ra[i] = $urandom;
        rw[i] = 1'($urandom);
        wv[i] = rw[i] ? $urandom : 32'h0;
        if (mask[i]) set_req(i, 1'b1, rw[i], ra[i], wv[i]);
      end
      m = mask;
      while (m != 0) begin
        idx = p;
        for (int k = 0; k < 4; k++) begin
          idx = (p + k) % 4;
          if (m[idx]) break;
        end
        push(2'(idx), rw[idx], ra[idx], wv[idx], rv, 1'b0);
        m[idx] = 1'b0;
        p = (idx + 1) % 4;
      end
      pend = mask;
      cyc = 0;
      m_pready = 1'($urandom);
      while (pend != 0 && cyc < 200) begin
        @(negedge clk);
        seen = s_pready;
        tick;
        s_psel = s_psel & ~seen;
        s_penable = s_penable & ~seen;
        pend = pend & ~seen;
        m_pready = 1'($urandom);
        cyc++;
      end
      vecs++;
      if (pend != 0) begin
        errs++;
        $display("FAIL rand_timeout: round %0d pending=%b, required 0000", r, pend);
      end
      s_psel = '0;
      s_penable = '0;
    end
  endtask

  task automatic test_drain;
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d completions outstanding, required 0", q.size());
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_wait_read;
    test_reset_mid;
    test_protocol;
    test_random;
    test_drain;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
